// File: rtl/btn_intr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_intr_arbiter                                             |
// | Description : Latches button one-shots as pending requests and serves them |
// |               round-robin on a single acknowledged interrupt line.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module btn_intr_arbiter #(
   parameter int          N_BTN            = 4,
   parameter logic [7:0]  ACK_TIMEOUT_CLKS = 8'hFF,
   parameter logic [7:0]  GAP_CLKS         = 8'h10
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [N_BTN-1:0]           BTN_PULSE,
   input  logic                       INTR_ACK,
   input  logic                       OVERRUN_CLR,
   output logic                       INTR,
   output logic [$clog2(N_BTN)-1:0]   BTN_ID,
   output logic [N_BTN-1:0]           PENDING,
   output logic [N_BTN-1:0]           OVERRUN,
   output logic                       TIMEOUT
);

   localparam int                 c_ID_W     = $clog2(N_BTN);
   localparam logic [c_ID_W-1:0]  c_LAST_RST = c_ID_W'(N_BTN - 1);
   localparam logic [7:0]         c_TO_LAST  = ACK_TIMEOUT_CLKS - 8'd1;
   localparam logic [7:0]         c_GAP_LAST = GAP_CLKS - 8'd1;

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_ASSERT = 2'd1;
   localparam logic [1:0] c_ST_GAP    = 2'd2;

   logic [1:0]         r_state;
   logic [7:0]         r_cnt;
   logic [c_ID_W-1:0]  r_last;
   logic [N_BTN-1:0]   r_pulse_q;

   logic [N_BTN-1:0]   w_rise;
   logic [N_BTN-1:0]   w_clr;
   logic [N_BTN-1:0]   w_ovr_set;
   logic [c_ID_W-1:0]  w_winner;
   logic [c_ID_W-1:0]  w_idx_n;
   logic               w_any;
   logic               w_grant;
   int                 w_idx;

   assign w_rise  = BTN_PULSE & ~r_pulse_q;
   assign w_grant = (r_state == c_ST_IDLE) && w_any;

   // Search starts one past the last winner and wraps, first pending index wins.
   always_comb begin
      w_winner = '0;
      w_any    = 1'b0;
      w_idx    = 0;
      w_idx_n  = '0;
      for (int k = 1; k <= N_BTN; k++) begin
         w_idx = int'(r_last) + k;
         if (w_idx >= N_BTN) begin
            w_idx = w_idx - N_BTN;
         end
         w_idx_n = w_idx[c_ID_W-1:0];
         if (!w_any && PENDING[w_idx_n]) begin
            w_any    = 1'b1;
            w_winner = w_idx_n;
         end
      end
   end

   always_comb begin
      w_clr = '0;
      if (w_grant) begin
         w_clr[w_winner] = 1'b1;
      end
   end

   // A rise on the bit being granted re-arms it rather than counting as overrun.
   assign w_ovr_set = w_rise & PENDING & ~w_clr;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pulse_q <= '0;
         PENDING   <= '0;
         OVERRUN   <= '0;
      end else begin
         r_pulse_q <= BTN_PULSE;
         PENDING   <= (PENDING & ~w_clr) | w_rise;
         OVERRUN   <= (OVERRUN & ~{N_BTN{OVERRUN_CLR}}) | w_ovr_set;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= c_ST_IDLE;
         r_cnt   <= 8'd0;
         r_last  <= c_LAST_RST;
         INTR    <= 1'b0;
         BTN_ID  <= '0;
         TIMEOUT <= 1'b0;
      end else begin
         TIMEOUT <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               INTR <= 1'b0;
               if (w_grant) begin
                  BTN_ID  <= w_winner;
                  r_last  <= w_winner;
                  INTR    <= 1'b1;
                  r_cnt   <= 8'd0;
                  r_state <= c_ST_ASSERT;
               end
            end
            c_ST_ASSERT: begin
               if (INTR_ACK) begin
                  INTR    <= 1'b0;
                  r_cnt   <= 8'd0;
                  r_state <= c_ST_GAP;
               end else if (r_cnt == c_TO_LAST) begin
                  INTR    <= 1'b0;
                  TIMEOUT <= 1'b1;
                  r_cnt   <= 8'd0;
                  r_state <= c_ST_GAP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            c_ST_GAP: begin
               INTR <= 1'b0;
               if (r_cnt == c_GAP_LAST) begin
                  r_cnt   <= 8'd0;
                  r_state <= c_ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               INTR    <= 1'b0;
               r_cnt   <= 8'd0;
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btn_intr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_btn_intr_arbiter                                          |
// | Description : Directed and random stimulus for btn_intr_arbiter against a  |
// |               behavioural request/serve model.                             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_btn_intr_arbiter;

   localparam int N      = 4;
   localparam int TO_MAX = 255;
   localparam int GAP    = 16;

   logic          CLK;
   logic          RST_N;
   logic [N-1:0]  BTN_PULSE;
   logic          INTR_ACK;
   logic          OVERRUN_CLR;
   logic          INTR;
   logic [1:0]    BTN_ID;
   logic [N-1:0]  PENDING;
   logic [N-1:0]  OVERRUN;
   logic          TIMEOUT;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: requests, who was served, how long the line has been up.
   logic [N-1:0]  m_pend, m_ovr, m_prev;
   logic          m_intr, m_to;
   int            m_id, m_last, m_phase, m_held, m_gap_left;

   btn_intr_arbiter #(
      .N_BTN(N), .ACK_TIMEOUT_CLKS(8'hFF), .GAP_CLKS(8'h10)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .BTN_PULSE(BTN_PULSE), .INTR_ACK(INTR_ACK),
      .OVERRUN_CLR(OVERRUN_CLR), .INTR(INTR), .BTN_ID(BTN_ID),
      .PENDING(PENDING), .OVERRUN(OVERRUN), .TIMEOUT(TIMEOUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_ovr = '0; m_prev = '0;
      m_intr = 1'b0; m_to = 1'b0; m_id = 0; m_last = N - 1;
      m_phase = 0; m_held = 0; m_gap_left = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] rise, clr, newov;
      bit found;
      int i;
      if (!RST_N) begin
         model_reset();
         return;
      end
      rise = BTN_PULSE & ~m_prev;
      m_prev = BTN_PULSE;
      clr = '0;
      m_to = 1'b0;
      if (m_phase == 0) begin
         if (m_pend != '0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               i = (m_last + k) % N;
               if (!found && m_pend[i]) begin
                  found = 1; clr[i] = 1'b1; m_id = i; m_last = i;
               end
            end
            m_intr = 1'b1; m_held = 1; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (INTR_ACK) begin
            m_intr = 1'b0; m_phase = 2; m_gap_left = GAP;
         end else if (m_held == TO_MAX) begin
            m_intr = 1'b0; m_to = 1'b1; m_phase = 2; m_gap_left = GAP;
         end else begin
            m_held++;
         end
      end else begin
         m_gap_left--;
         if (m_gap_left == 0) m_phase = 0;
      end
      newov  = rise & m_pend & ~clr;
      m_pend = (m_pend & ~clr) | rise;
      if (OVERRUN_CLR) m_ovr = '0;
      m_ovr = m_ovr | newov;
   endtask

   task automatic check_all();
      check("intr",    32'(INTR),    32'(m_intr));
      check("btn_id",  32'(BTN_ID),  32'(m_id));
      check("pending", 32'(PENDING), 32'(m_pend));
      check("overrun", 32'(OVERRUN), 32'(m_ovr));
      check("timeout", 32'(TIMEOUT), 32'(m_to));
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
      check_all();
   endtask

   task automatic wait_intr(input int budget, input string tag);
      int n = 0;
      while (INTR !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(INTR), 32'd1);
   endtask

   task automatic ack_now();
      INTR_ACK = 1'b1;
      tick();
      INTR_ACK = 1'b0;
   endtask

   initial begin
      int hi, lo, to_cnt, rises;
      logic prev_intr;
      logic [31:0] r;

      RST_N = 1'b0; BTN_PULSE = '0; INTR_ACK = 1'b0; OVERRUN_CLR = 1'b0;
      model_reset();
      #3;
      check_all();
      tick(); tick();
      @(negedge CLK);
      RST_N = 1'b1;

      // Held pulse gives one request; ack after five cycles up.
      BTN_PULSE = 4'b0100;
      tick();
      tick();
      check("t1_intr_up", 32'(INTR), 32'd1);
      check("t1_id", 32'(BTN_ID), 32'd2);
      check("t1_pend_clr", 32'(PENDING), 32'd0);
      hi = 1;
      repeat (4) begin tick(); if (INTR) hi++; end
      ack_now();
      check("t1_hi_cycles", 32'(hi), 32'd5);
      check("t1_intr_down", 32'(INTR), 32'd0);
      rises = 0; prev_intr = 1'b0;
      repeat (2) tick();
      BTN_PULSE = '0;
      repeat (30) begin tick(); if (INTR && !prev_intr) rises++; prev_intr = INTR; end
      check("t1_no_regrant", 32'(rises), 32'd0);

      // Simultaneous requests after reset, then wraparound after LAST=3.
      tick();
      #2 RST_N = 1'b0; model_reset();
      #1 check_all();
      tick();
      @(negedge CLK);
      RST_N = 1'b1;
      BTN_PULSE = 4'b1001;
      tick();
      BTN_PULSE = '0;
      tick();
      check("t2_first", 32'(BTN_ID), 32'd0);
      ack_now();
      wait_intr(40, "t2_wait3");
      check("t2_second", 32'(BTN_ID), 32'd3);
      ack_now();
      BTN_PULSE = 4'b0011;
      tick();
      BTN_PULSE = '0;
      wait_intr(40, "t2_wait0");
      check("t2_third", 32'(BTN_ID), 32'd0);
      ack_now();
      wait_intr(40, "t2_wait1");
      check("t2_fourth", 32'(BTN_ID), 32'd1);
      ack_now();

      // Double request on button 1 while button 0 is being served.
      BTN_PULSE = 4'b0001;
      tick();
      BTN_PULSE = '0;
      wait_intr(40, "t3_wait0");
      BTN_PULSE = 4'b0010; tick();
      BTN_PULSE = 4'b0000; tick();
      BTN_PULSE = 4'b0010; tick();
      BTN_PULSE = 4'b0000; tick();
      check("t3_overrun", 32'(OVERRUN), 32'h2);
      check("t3_pending", 32'(PENDING), 32'h2);
      ack_now();
      wait_intr(40, "t3_wait1");
      check("t3_id1", 32'(BTN_ID), 32'd1);
      ack_now();
      hi = 0;
      repeat (40) begin tick(); if (INTR) hi++; end
      check("t3_single_grant", 32'(hi), 32'd0);
      OVERRUN_CLR = 1'b1; tick(); OVERRUN_CLR = 1'b0;
      check("t3_ovr_clr", 32'(OVERRUN), 32'd0);

      // No acknowledge: full timeout, one-cycle TIMEOUT, gap, next request.
      BTN_PULSE = 4'b0100; tick();
      BTN_PULSE = '0;
      wait_intr(40, "t4_wait2");
      BTN_PULSE = 4'b1000; tick(); BTN_PULSE = '0;
      hi = 2; to_cnt = 0;
      while (INTR === 1'b1 && hi < 300) begin
         tick();
         if (TIMEOUT) to_cnt++;
         if (INTR) hi++;
      end
      check("t4_hi_cycles", 32'(hi), 32'd255);
      check("t4_timeout_now", 32'(TIMEOUT), 32'd1);
      lo = 1;
      while (INTR !== 1'b1 && lo < 40) begin
         tick();
         if (TIMEOUT) to_cnt++;
         if (!INTR) lo++;
      end
      // 16 cycles in the gap plus the idle cycle that makes the grant.
      check("t4_lo_cycles", 32'(lo), 32'd17);
      check("t4_to_pulses", 32'(to_cnt), 32'd1);
      check("t4_next_id", 32'(BTN_ID), 32'd3);
      ack_now();

      // Asynchronous reset while serving, with requests and an overrun pending.
      BTN_PULSE = 4'b0001; tick(); BTN_PULSE = '0;
      wait_intr(40, "t5_wait0");
      BTN_PULSE = 4'b0110; tick();
      BTN_PULSE = 4'b0000; tick();
      BTN_PULSE = 4'b0100; tick();
      BTN_PULSE = 4'b0000; tick();
      check("t5_pre_pend", 32'(PENDING), 32'h6);
      check("t5_pre_ovr", 32'(OVERRUN), 32'h4);
      #2 RST_N = 1'b0; model_reset();
      #1;
      check("t5_rst_intr", 32'(INTR), 32'd0);
      check("t5_rst_pend", 32'(PENDING), 32'd0);
      check("t5_rst_ovr", 32'(OVERRUN), 32'd0);
      check("t5_rst_id", 32'(BTN_ID), 32'd0);
      tick(); tick();
      @(negedge CLK);
      RST_N = 1'b1;
      BTN_PULSE = 4'b1000; tick(); BTN_PULSE = '0;
      wait_intr(40, "t5_wait3");
      check("t5_id3", 32'(BTN_ID), 32'd3);
      ack_now();

      // Ack on the timeout-threshold cycle, then a rise on the grant edge.
      BTN_PULSE = 4'b0001; tick(); BTN_PULSE = '0;
      wait_intr(40, "t6_wait0");
      repeat (254) tick();
      check("t6_still_up", 32'(INTR), 32'd1);
      ack_now();
      check("t6_no_timeout", 32'(TIMEOUT), 32'd0);
      check("t6_down", 32'(INTR), 32'd0);
      BTN_PULSE = 4'b0010; tick();
      BTN_PULSE = '0;
      repeat (15) tick();
      BTN_PULSE = 4'b0010; tick();
      check("t6_grant_up", 32'(INTR), 32'd1);
      check("t6_grant_id", 32'(BTN_ID), 32'd1);
      check("t6_rearm_pend", 32'(PENDING), 32'h2);
      check("t6_rearm_ovr", 32'(OVERRUN), 32'd0);
      BTN_PULSE = '0;
      ack_now();
      wait_intr(40, "t6_wait1b");
      check("t6_reserve_id", 32'(BTN_ID), 32'd1);
      ack_now();

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         r = $urandom;
         if (r[2:0] == 3'd0) BTN_PULSE = r[N+2:3];
         INTR_ACK    = r[8] & r[9];
         OVERRUN_CLR = (r[15:12] == 4'd0);
         tick();
      end
      INTR_ACK = 1'b0; OVERRUN_CLR = 1'b0; BTN_PULSE = '0;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btn_intr_arbiter.md
Name: btn_intr_arbiter

Overview:
- Collects one-shot pulses from N debounced buttons (one debounce_one_shot instance per button) and latches each as a pending request.
- Round-robin arbitrates pending requests onto the single MCU interrupt line (INTR), presenting the winning button index on BTN_ID.
- Waits for the MCU acknowledge or a timeout, then enforces a minimum gap before issuing the next interrupt.
- Sits between the button debouncers and the MCU interrupt input; 50 MHz MCU clock domain.

Parameters:
- N_BTN, 4, number of button request inputs (2..8).
- ACK_TIMEOUT_CLKS, 8'hFF, maximum cycles INTR is held without INTR_ACK.
- GAP_CLKS, 8'h10, idle cycles enforced after each interrupt ends.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- BTN_PULSE  in  N_BTN  one-shot outputs of the debouncers; may stay high for several cycles.
- INTR_ACK  in  1  MCU acknowledge, sampled only in ST_ASSERT.
- OVERRUN_CLR  in  1  clears all OVERRUN bits.
- INTR  out  1  interrupt request to the MCU, registered.
- BTN_ID  out  clog2(N_BTN)  index of the granted button, registered.
- PENDING  out  N_BTN  latched, not-yet-served requests.
- OVERRUN  out  N_BTN  sticky: a request arrived while the same bit was already pending.
- TIMEOUT  out  1  one-cycle pulse when INTR ends without an acknowledge.

Behaviour:
- Reset (async, RST_N=0):
  - INTR=0, BTN_ID=0, PENDING=0, OVERRUN=0, TIMEOUT=0.
  - Edge-detect history=0, counter=0, state=ST_IDLE.
  - Round-robin pointer LAST=N_BTN-1, so the first search starts at index 0.
  - Reset mid-interrupt drops INTR immediately, without waiting for a clock edge.
- Edge detection:
  - BTN_PULSE_q registered each cycle; rise[i] = BTN_PULSE[i] & ~BTN_PULSE_q[i].
  - A pulse held high produces exactly one request.
- Pending latch:
  - A rise sampled at edge k gives PENDING[i]=1 after edge k.
  - A rise while PENDING[i]=1 already (and not being cleared that cycle) sets OVERRUN[i]=1; the request is not duplicated.
  - A rise in the same cycle a grant clears that bit: the rise wins, PENDING stays 1, no overrun.
  - OVERRUN_CLR clears OVERRUN; a simultaneous new overrun wins, so the bit stays set.
- Arbitration:
  - Search order is LAST+1, LAST+2, ... modulo N_BTN; the first pending index wins.
- FSM (8-bit counter CNT, reset on every state change):
  - ST_IDLE: INTR=0.
    - If PENDING!=0 at an edge: BTN_ID←winner, LAST←winner, PENDING[winner]←0, INTR←1, go ST_ASSERT.
    - Latency: rise sampled at edge k, INTR high after edge k+1.
  - ST_ASSERT: INTR=1, BTN_ID stable.
    - INTR_ACK=1: INTR←0 at that edge, go ST_GAP.
    - Else if CNT==ACK_TIMEOUT_CLKS-1: INTR←0, TIMEOUT=1 for one cycle, go ST_GAP.
    - Else CNT++.
    - ACK wins over a timeout in the same cycle.
  - ST_GAP: INTR=0, BTN_ID holds the last value.
    - CNT++ until CNT==GAP_CLKS-1, then go ST_IDLE.
    - New requests keep latching during the gap.
  - Any illegal state: go ST_IDLE, INTR=0.
- INTR_ACK is ignored outside ST_ASSERT.
- BTN_ID changes only on a grant.

Test Plan:
1. BTN_PULSE[2] high for 9 clks, ACK 5 clks after INTR rises -> exactly one INTR, BTN_ID=2, INTR high 5 clks; PENDING[2]=0 from the grant edge on; next grant no earlier than 16 clks after INTR falls.
2. BTN_PULSE[0] and [3] rise in the same cycle after reset; each ACK issued promptly -> grants BTN_ID=0 then 3. Then [0] and [1] rise together -> grants 0 then 1 (search starts after LAST=3).
3. BTN_PULSE[1] rises twice while PENDING[1]=1 (during another button's ASSERT) -> OVERRUN[1]=1, only one grant for button 1. OVERRUN_CLR pulse -> OVERRUN=0.
4. Request with no ACK -> INTR high exactly 255 clks, TIMEOUT pulses 1 clk, 16-clk gap, then the next pending request is granted.
5. RST_N pulled low mid-ST_ASSERT with two requests pending -> INTR, PENDING, OVERRUN and BTN_ID all 0 without a clock edge. After release, a new BTN_PULSE[3] -> grant BTN_ID=3 (LAST was reset, search starts at 0).
6. ACK and the timeout-threshold cycle coincide -> TIMEOUT stays 0, normal gap. Rise on the same bit in the grant cycle -> PENDING stays 1, OVERRUN stays 0, the bit is served again after the gap.
